index_decoder: RTL and testbench
================================

# index_decoder

Sequential index-to-vector decoder. It is the receive-side counterpart of the combinational priority encoder. A frame of bit indices arrives one per beat over a valid/ready stream, and the block sets the corresponding bits in an accumulating vector. On the frame's last beat it presents the assembled vector, along with the lowest set index and its thermometer mask, on a registered valid/ready output. It sits between a serializer that emits set-bit positions and logic that consumes the reconstructed bit vector.

## Interface
Parameters:
- OUTPUT_WIDTH, 8, number of vector bits W; legal range 2..256; need not be a power of two.
- IW (localparam), $clog2(OUTPUT_WIDTH), index width.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  index beat valid.
- in_ready  output  1  block can accept a beat.
- in_index  input  IW  bit position to set.
- in_last  input  1  final beat of frame.
- out_valid  output  1  assembled frame available.
- out_ready  input  1  consumer accepts frame.
- out_bits  output  W  assembled vector.
- out_lowest  output  IW  index of lowest set bit of out_bits; 0 if out_bits is zero.
- out_mask  output  W  thermometer mask, bits [out_lowest-1:0] set; all-zero if out_lowest is 0 or out_bits is zero.
- out_dup  output  1  at least one beat in the frame repeated an already-set index.
- out_range_err  output  1  at least one beat carried in_index >= W.

## Operation
- Two states:
  - COLLECT (reset state): in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- A beat is accepted when in_valid && in_ready.
- Accepted beat with in_index < W:
  - acc[in_index] <= 1.
  - If acc[in_index] was already 1, the dup flag is set.
- Accepted beat with in_index >= W:
  - acc is unchanged.
  - The range_err flag is set.
- Accepted beat with in_last=1:
  - Transition COLLECT -> HOLD.
  - out_bits, out_dup and out_range_err load the final values, including that beat's contribution.
  - out_lowest and out_mask are computed from the final vector and registered.
  - acc, dup and range_err clear to 0 for the next frame.
- HOLD -> COLLECT when out_valid && out_ready. Outputs hold stable while out_valid=1 && out_ready=0.
- Single-beat frames are legal: in_last=1 on the first beat.
- Frames with no in-range index are legal. They produce out_bits=0, out_lowest=0, out_mask=0, out_range_err=1.
- out_lowest is a lowest-first priority encode of the final vector. It must satisfy:
  - out_bits[out_lowest]=1 whenever out_bits is nonzero.
  - (out_bits & out_mask)==0 always.
- Beat order within a frame does not affect out_bits.
- in_index, in_last, out_ready values are ignored whenever their qualifying valid is low.

## Timing
- Reset (rst_n low, asynchronous):
  - State = COLLECT.
  - acc, dup and range_err are cleared.
  - out_valid=0, out_bits=0, out_lowest=0, out_mask=0, out_dup=0, out_range_err=0.
  - in_ready=1 after reset.
- Reset asserted mid-frame or during HOLD discards the partial or pending frame. No output is produced for it.
- Latency: out_valid rises the cycle after the last beat is accepted.
- in_ready is a registered function of state only. It never depends combinationally on in_valid or out_ready.
- Throughput:
  - An N-beat frame occupies N cycles of COLLECT plus at least 1 cycle of HOLD.
  - Minimum period between frames is N+1 cycles when out_ready is held high.
  - in_ready reasserts the cycle after the output handshake; no same-cycle pass-through.
- Duplicate and out-of-range beats consume one cycle like any other beat.

## Test plan
- W=8, beats 5,2,6(last), out_ready=1:
  - out_valid one cycle after the last beat.
  - out_bits=8'b0110_0100, out_lowest=2, out_mask=8'b0000_0011, out_dup=0, out_range_err=0.
- W=5, beats 4,7,1,4(last):
  - out_bits=5'b10010, out_lowest=1, out_mask=5'b00001, out_dup=1, out_range_err=1.
- W=3, single beat 3 with last:
  - out_bits=0, out_lowest=0, out_mask=0, out_range_err=1.
  - Next frame, beat 0 with last, gives out_bits=3'b001 with both flags cleared.
- W=8, frame beat 7(last), out_ready held low 5 cycles:
  - out_valid and all outputs stable for 5 cycles; in_ready=0 throughout.
  - A second frame offered meanwhile is not accepted until the cycle after the handshake.
- W=2, back-to-back single-beat frames 1 then 0, out_ready=1:
  - Outputs 2'b10 (lowest 1, mask 2'b01), then 2'b01 (lowest 0, mask 0).
  - Frames are 2 cycles apart.
- W=8, beats 3,1 accepted, then rst_n pulsed low asynchronously, then beat 6(last):
  - No output for the aborted frame.
  - Single output out_bits=8'b0100_0000, out_lowest=6, out_mask=8'b0011_1111.
- Randomized W=8 frames: scoreboard the OR of indices and check the out_lowest/out_mask invariants on every frame.

Source files
------------

// File: rtl/index_decoder.sv
// index_decoder: collects a frame of bit indices (one per beat) into a vector
// and presents the vector, its lowest set index and the thermometer mask
// below that index on a registered valid/ready output.
module index_decoder #(
    parameter  int OUTPUT_WIDTH = 8,
    localparam int IW           = $clog2(OUTPUT_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IW-1:0]           in_index,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_bits,
    output logic [IW-1:0]           out_lowest,
    output logic [OUTPUT_WIDTH-1:0] out_mask,
    output logic                    out_dup,
    output logic                    out_range_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // One extra bit so that OUTPUT_WIDTH itself is representable when W is a power of two.
    localparam logic [IW:0] W_LIMIT = (IW + 1)'(OUTPUT_WIDTH);

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [OUTPUT_WIDTH-1:0] r_acc;
    logic                    r_dup;
    logic                    r_range_err;
    logic [OUTPUT_WIDTH-1:0] r_out_bits;
    logic [IW-1:0]           r_out_lowest;
    logic [OUTPUT_WIDTH-1:0] r_out_mask;
    logic                    r_out_dup;
    logic                    r_out_range_err;

    logic                    w_in_range;
    logic [OUTPUT_WIDTH-1:0] w_onehot;
    logic [OUTPUT_WIDTH-1:0] w_acc_next;
    logic                    w_dup_next;
    logic                    w_range_next;
    logic [IW-1:0]           w_lowest;
    logic [OUTPUT_WIDTH-1:0] w_mask;

    assign w_in_range = ({1'b0, in_index} < W_LIMIT);

    // Out-of-range indices decode to an all-zero vector so they never touch the accumulator.
    for (genvar gi = 0; gi < OUTPUT_WIDTH; gi++) begin : g_decode
        assign w_onehot[gi] = w_in_range && (in_index == IW'(gi));
    end

    assign w_acc_next   = r_acc | w_onehot;
    assign w_dup_next   = r_dup | (|(r_acc & w_onehot));
    assign w_range_next = r_range_err | ~w_in_range;

    // Lowest-first priority encode of the vector as it will be after this beat; 0 when empty.
    always_comb begin
        w_lowest = '0;
        for (int i = OUTPUT_WIDTH - 1; i >= 0; i--) begin
            if (w_acc_next[i]) begin
                w_lowest = IW'(i);
            end
        end
    end

    // Thermometer below the lowest index; an empty vector encodes to 0, giving an empty mask.
    for (genvar gi = 0; gi < OUTPUT_WIDTH; gi++) begin : g_mask
        assign w_mask[gi] = (IW'(gi) < w_lowest);
    end

    // Frame FSM: accumulate in COLLECT, publish on the last beat, wait in HOLD for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= COLLECT;
            r_in_ready      <= 1'b1;
            r_out_valid     <= 1'b0;
            r_acc           <= '0;
            r_dup           <= 1'b0;
            r_range_err     <= 1'b0;
            r_out_bits      <= '0;
            r_out_lowest    <= '0;
            r_out_mask      <= '0;
            r_out_dup       <= 1'b0;
            r_out_range_err <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (in_valid) begin
                        if (in_last) begin
                            r_out_bits      <= w_acc_next;
                            r_out_lowest    <= w_lowest;
                            r_out_mask      <= w_mask;
                            r_out_dup       <= w_dup_next;
                            r_out_range_err <= w_range_next;
                            r_acc           <= '0;
                            r_dup           <= 1'b0;
                            r_range_err     <= 1'b0;
                            r_state         <= HOLD;
                            r_in_ready      <= 1'b0;
                            r_out_valid     <= 1'b1;
                        end else begin
                            r_acc       <= w_acc_next;
                            r_dup       <= w_dup_next;
                            r_range_err <= w_range_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= COLLECT;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= COLLECT;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_bits      = r_out_bits;
    assign out_lowest    = r_out_lowest;
    assign out_mask      = r_out_mask;
    assign out_dup       = r_out_dup;
    assign out_range_err = r_out_range_err;

endmodule

// File: tb/tb_index_decoder.sv
// Testbench for index_decoder: four instances (W = 8, 5, 3, 2), a frame-level
// reference model feeding an expectation queue, and one per-cycle compare process.
module tb_index_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [3:0]      iv;
    logic [3:0]      il;
    logic [3:0]      ordy;
    logic [3:0][7:0] ii;
    logic [3:0]      ir_a;
    logic [3:0]      ov_a;
    logic [3:0]      od_a;
    logic [3:0]      oe_a;
    logic [3:0][7:0] ob_a;
    logic [3:0][7:0] ol_a;
    logic [3:0][7:0] om_a;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int accept_cyc = 0;
    int beats [16];

    typedef struct {
        int         d;
        logic [7:0] bits;
        int         lowest;
        logic [7:0] mask;
        logic       dup;
        logic       rerr;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int w_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 5 : (d == 2) ? 3 : 2;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int W  = (gi == 0) ? 8 : (gi == 1) ? 5 : (gi == 2) ? 3 : 2;
        localparam int IW = $clog2(W);
        logic          w_ir, w_ov, w_od, w_oe;
        logic [W-1:0]  w_ob, w_om;
        logic [IW-1:0] w_ol;

        index_decoder #(.OUTPUT_WIDTH(W)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid     (iv[gi]),
            .in_ready     (w_ir),
            .in_index     (ii[gi][IW-1:0]),
            .in_last      (il[gi]),
            .out_valid    (w_ov),
            .out_ready    (ordy[gi]),
            .out_bits     (w_ob),
            .out_lowest   (w_ol),
            .out_mask     (w_om),
            .out_dup      (w_od),
            .out_range_err(w_oe)
        );

        assign ir_a[gi] = w_ir;
        assign ov_a[gi] = w_ov;
        assign od_a[gi] = w_od;
        assign oe_a[gi] = w_oe;
        assign ob_a[gi] = 8'(w_ob);
        assign ol_a[gi] = 8'(w_ol);
        assign om_a[gi] = 8'(w_om);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Frame-level model: OR of in-range indices, flags from the beat list,
    // lowest found by scanning upward, mask = all positions below lowest.
    function automatic exp_t compute_exp(input int d, input int n);
        exp_t e;
        int   w;
        w        = w_of(d);
        e.d      = d;
        e.bits   = '0;
        e.dup    = 1'b0;
        e.rerr   = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (beats[k] >= w) e.rerr = 1'b1;
            else begin
                if (e.bits[beats[k]]) e.dup = 1'b1;
                e.bits[beats[k]] = 1'b1;
            end
        end
        e.lowest = 0;
        for (int k = 0; k < w; k++) begin
            if (e.bits[k]) begin
                e.lowest = k;
                break;
            end
        end
        e.mask = '0;
        for (int k = 0; k < e.lowest; k++) e.mask[k] = 1'b1;
        return e;
    endfunction

    // Offer one beat (inputs change 1 time unit after the clock edge) and wait for acceptance.
    task automatic send_beat(input int d, input int idx, input logic last);
        int cnt;
        iv[d] = 1'b1;
        ii[d] = 8'(idx);
        il[d] = last;
        cnt   = 0;
        while (!ir_a[d] && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 200) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        il[d] = 1'b0;
        accept_cyc = cyc;
        if (last) begin
            chk("latency_out_valid", 32'(ov_a[d]), 32'd1);
            chk("latency_in_ready", 32'(ir_a[d]), 32'd0);
        end
    endtask

    task automatic send_frame(input int d, input int n);
        exp_q.push_back(compute_exp(d, n));
        for (int k = 0; k < n; k++) send_beat(d, beats[k], (k == n - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pin(input string name, input int d, input int n, input logic [7:0] bits,
                       input int lowest, input logic [7:0] mask, input logic dup, input logic rerr);
        exp_t e;
        e = compute_exp(d, n);
        chk({name, "_model_bits"}, 32'(e.bits), 32'(bits));
        chk({name, "_model_lowest"}, 32'(e.lowest), 32'(lowest));
        chk({name, "_model_mask"}, 32'(e.mask), 32'(mask));
        chk({name, "_model_flags"}, {30'd0, e.dup, e.rerr}, {30'd0, dup, rerr});
    endtask

    // Per-cycle compare: handshake/state coupling, stall stability, invariants, scoreboard.
    logic [3:0]      pv, pr, pd, pe;
    logic [3:0][7:0] pb, pl, pm;

    always @(negedge clk) begin
        if (!rst_n) begin
            pv = '0;
            pr = '0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                chk("in_ready_vs_out_valid", 32'(ir_a[d]), 32'(!ov_a[d]));
                if (ov_a[d]) begin
                    if (pv[d] && !pr[d]) begin
                        chk("stall_stable_bits", 32'(ob_a[d]), 32'(pb[d]));
                        chk("stall_stable_lowest", 32'(ol_a[d]), 32'(pl[d]));
                        chk("stall_stable_mask", 32'(om_a[d]), 32'(pm[d]));
                        chk("stall_stable_flags", {30'd0, od_a[d], oe_a[d]}, {30'd0, pd[d], pe[d]});
                    end
                    chk("inv_bits_and_mask", 32'(ob_a[d] & om_a[d]), 32'd0);
                    if (ob_a[d] != 0) chk("inv_lowest_set", 32'(ob_a[d][ol_a[d][2:0]]), 32'd1);
                    if (ordy[d]) begin
                        if (exp_q.size() == 0 || exp_q[0].d != d) begin
                            chk("unexpected_frame", 32'(d), 32'hFFFF);
                        end else begin
                            chk("out_bits", 32'(ob_a[d]), 32'(exp_q[0].bits));
                            chk("out_lowest", 32'(ol_a[d]), 32'(exp_q[0].lowest));
                            chk("out_mask", 32'(om_a[d]), 32'(exp_q[0].mask));
                            chk("out_dup", 32'(od_a[d]), 32'(exp_q[0].dup));
                            chk("out_range_err", 32'(oe_a[d]), 32'(exp_q[0].rerr));
                            $display("frame dut=%0d bits=%0h lowest=%0d mask=%0h dup=%0b rerr=%0b",
                                     d, ob_a[d], ol_a[d], om_a[d], od_a[d], oe_a[d]);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                pv[d] = ov_a[d];
                pr[d] = ordy[d];
                pb[d] = ob_a[d];
                pl[d] = ol_a[d];
                pm[d] = om_a[d];
                pd[d] = od_a[d];
                pe[d] = oe_a[d];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int n;
        iv   = '0;
        il   = '0;
        ii   = '0;
        ordy = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state on every instance
        for (int d = 0; d < 4; d++) begin
            chk("reset_in_ready", 32'(ir_a[d]), 32'd1);
            chk("reset_out_valid", 32'(ov_a[d]), 32'd0);
            chk("reset_outputs", {ob_a[d], ol_a[d], om_a[d]}, 32'd0);
            chk("reset_flags", {30'd0, od_a[d], oe_a[d]}, 32'd0);
        end

        // W=8: 5,2,6(last)
        beats[0] = 5; beats[1] = 2; beats[2] = 6;
        pin("w8_basic", 0, 3, 8'b0110_0100, 2, 8'b0000_0011, 1'b0, 1'b0);
        send_frame(0, 3);
        idle(2);

        // W=5: 4,7,1,4(last)
        beats[0] = 4; beats[1] = 7; beats[2] = 1; beats[3] = 4;
        pin("w5_dup_range", 1, 4, 8'b0001_0010, 1, 8'b0000_0001, 1'b1, 1'b1);
        send_frame(1, 4);
        idle(2);

        // W=3: out-of-range single beat, then beat 0
        beats[0] = 3;
        pin("w3_empty", 2, 1, 8'd0, 0, 8'd0, 1'b0, 1'b1);
        send_frame(2, 1);
        beats[0] = 0;
        pin("w3_zero", 2, 1, 8'b001, 0, 8'd0, 1'b0, 1'b0);
        send_frame(2, 1);
        idle(2);

        // W=8: frame 7(last) with out_ready low 5 cycles, second frame offered meanwhile
        ordy[0] = 1'b0;
        beats[0] = 7;
        pin("w8_stall", 0, 1, 8'h80, 7, 8'h7F, 1'b0, 1'b0);
        send_frame(0, 1);
        beats[0] = 3;
        exp_q.push_back(compute_exp(0, 1));
        iv[0] = 1'b1; ii[0] = 8'd3; il[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready_low", 32'(ir_a[0]), 32'd0);
            chk("stall_out_valid_high", 32'(ov_a[0]), 32'd1);
            @(posedge clk); #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("after_handshake_in_ready", 32'(ir_a[0]), 32'd1);
        chk("no_pass_through", 32'(ov_a[0]), 32'd0);
        @(posedge clk); #1;
        iv[0] = 1'b0; il[0] = 1'b0;
        chk("second_frame_out_valid", 32'(ov_a[0]), 32'd1);
        idle(2);

        // W=2: back-to-back single-beat frames 1 then 0, two cycles apart
        beats[0] = 1;
        pin("w2_one", 3, 1, 8'b10, 1, 8'b01, 1'b0, 1'b0);
        send_frame(3, 1);
        c1 = accept_cyc;
        beats[0] = 0;
        pin("w2_zero", 3, 1, 8'b01, 0, 8'b00, 1'b0, 1'b0);
        send_frame(3, 1);
        chk("w2_frame_spacing", 32'(accept_cyc - c1), 32'd2);
        idle(2);

        // W=8: partial frame 3,1 aborted by an asynchronous reset pulse
        send_beat(0, 3, 1'b0);
        send_beat(0, 1, 1'b0);
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("abort_in_ready", 32'(ir_a[0]), 32'd1);
        chk("abort_out_valid", 32'(ov_a[0]), 32'd0);
        @(posedge clk); #1;
        beats[0] = 6;
        pin("w8_after_abort", 0, 1, 8'b0100_0000, 6, 8'b0011_1111, 1'b0, 1'b0);
        send_frame(0, 1);
        idle(2);

        // Random W=8 frames with occasional consumer back-pressure
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) beats[k] = $urandom_range(0, 7);
            send_frame(0, n);
            if ($urandom_range(0, 2) == 0) begin
                ordy[0] = 1'b0;
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                end
                ordy[0] = 1'b1;
            end
        end
        idle(4);

        chk("all_frames_emitted", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
